// File: rtl/mpu_mem_pkg.sv
// Shared definitions for the memory access arbiter: FSM state encoding,
// requester (owner) identifiers and default bus widths.
package mpu_mem_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/mem_access_timer.sv
// Loadable down-counter that measures how long the memory enable is held;
// zero is asserted while the count is 0.
module mem_access_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en && count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one memory between the CPU path and the
// program loader; one access at a time, latched request, one-cycle ack.
module mem_access_arbiter
   import mpu_mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MEM_LAT = 1
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iCpuReq,
   input  logic              iCpuWe,
   input  logic [ADDR_W-1:0] iCpuAddr,
   input  logic [DATA_W-1:0] iCpuWdata,
   output logic              oCpuAck,
   output logic [DATA_W-1:0] oCpuRdata,
   input  logic              iLdrReq,
   input  logic              iLdrWe,
   input  logic [ADDR_W-1:0] iLdrAddr,
   input  logic [DATA_W-1:0] iLdrWdata,
   output logic              oLdrAck,
   output logic [DATA_W-1:0] oLdrRdata,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic [DATA_W-1:0] oMemWdata,
   output logic              oMemEn,
   output logic              oMemWe,
   input  logic [DATA_W-1:0] iMemRdata,
   output logic              oBusy,
   output logic              oOwner,
   output logic              oStallCpu
);

   localparam int               CNT_W    = 2;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

   generate
      if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
         $error("mem_access_arbiter: MEM_LAT=%0d is outside 1..4", MEM_LAT);
      end
   endgenerate

   state_t            state_reg, state_next;
   logic              owner_reg;
   logic              last_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic              we_reg;
   logic [DATA_W-1:0] cpu_rdata_reg, ldr_rdata_reg;
   logic              grant, grant_ldr, timer_zero;

   // Loader wins only when alone or when the CPU had the previous grant.
   assign grant     = (state_reg == IDLE) && (iCpuReq || iLdrReq);
   assign grant_ldr = iLdrReq && (!iCpuReq || last_reg == OWN_CPU);

   mem_access_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (iClk),
      .rst      (iRst),
      .load     (grant),
      .load_val (LAT_LOAD),
      .en       (state_reg == ACCESS),
      .zero     (timer_zero)
   );

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      oMemEn     = 1'b0;
      oMemWe     = 1'b0;
      oBusy      = 1'b0;
      oCpuAck    = 1'b0;
      oLdrAck    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant) state_next = ACCESS;
         end
         ACCESS: begin
            oMemEn = 1'b1;
            oMemWe = we_reg;
            oBusy  = 1'b1;
            if (timer_zero) state_next = RESP;
         end
         RESP: begin
            oBusy      = 1'b1;
            oCpuAck    = (owner_reg == OWN_CPU);
            oLdrAck    = (owner_reg == OWN_LDR);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // last_reg is kept apart from owner_reg so the CPU wins the first tie
   // while oOwner still resets to 0.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         owner_reg <= OWN_CPU;
         last_reg  <= OWN_LDR;
         addr_reg  <= '0;
         wdata_reg <= '0;
         we_reg    <= 1'b0;
      end else if (grant) begin
         owner_reg <= grant_ldr ? OWN_LDR : OWN_CPU;
         last_reg  <= grant_ldr ? OWN_LDR : OWN_CPU;
         addr_reg  <= grant_ldr ? iLdrAddr : iCpuAddr;
         wdata_reg <= grant_ldr ? iLdrWdata : iCpuWdata;
         we_reg    <= grant_ldr ? iLdrWe : iCpuWe;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         cpu_rdata_reg <= '0;
         ldr_rdata_reg <= '0;
      end else if (state_reg == ACCESS && timer_zero && !we_reg) begin
         if (owner_reg == OWN_CPU) begin
            cpu_rdata_reg <= iMemRdata;
         end else begin
            ldr_rdata_reg <= iMemRdata;
         end
      end
   end

   assign oMemAddr  = addr_reg;
   assign oMemWdata = wdata_reg;
   assign oOwner    = owner_reg;
   assign oCpuRdata = cpu_rdata_reg;
   assign oLdrRdata = ldr_rdata_reg;
   assign oStallCpu = iCpuReq & ~oCpuAck;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: two instances (MEM_LAT 1 and 3) with their own
// memory, checked against a transaction-level model of timing, arbitration and data.
module tb_mem_access_arbiter;

   localparam int N = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        cpu_req [N], cpu_we [N], ldr_req [N], ldr_we [N];
   logic [15:0] cpu_addr [N], ldr_addr [N], mem_addr [N];
   logic [7:0]  cpu_wdata [N], ldr_wdata [N], cpu_rdata [N], ldr_rdata [N];
   logic [7:0]  mem_wdata [N], mem_rdata [N];
   logic        cpu_ack [N], ldr_ack [N], mem_en [N], mem_we [N];
   logic        busy [N], owner [N], stall_cpu [N];

   logic [7:0]  mem [N][65536];
   logic        mem_ready = 1'b0;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  exp_cpu_rd [N];
   logic [7:0]  exp_ldr_rd [N];
   logic [7:0]  shadow [int];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_dut
         mem_access_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(gi == 0 ? 1 : 3)) u_dut (
            .iClk      (clk),
            .iRst      (rst),
            .iCpuReq   (cpu_req[gi]),
            .iCpuWe    (cpu_we[gi]),
            .iCpuAddr  (cpu_addr[gi]),
            .iCpuWdata (cpu_wdata[gi]),
            .oCpuAck   (cpu_ack[gi]),
            .oCpuRdata (cpu_rdata[gi]),
            .iLdrReq   (ldr_req[gi]),
            .iLdrWe    (ldr_we[gi]),
            .iLdrAddr  (ldr_addr[gi]),
            .iLdrWdata (ldr_wdata[gi]),
            .oLdrAck   (ldr_ack[gi]),
            .oLdrRdata (ldr_rdata[gi]),
            .oMemAddr  (mem_addr[gi]),
            .oMemWdata (mem_wdata[gi]),
            .oMemEn    (mem_en[gi]),
            .oMemWe    (mem_we[gi]),
            .iMemRdata (mem_rdata[gi]),
            .oBusy     (busy[gi]),
            .oOwner    (owner[gi]),
            .oStallCpu (stall_cpu[gi])
         );
         assign mem_rdata[gi] = mem[gi][mem_addr[gi]];
      end
   endgenerate

   function automatic logic [7:0] init_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic logic [7:0] exp_mem(input int d, input logic [15:0] a);
      int key;
      key = d * 65536 + int'(a);
      return shadow.exists(key) ? shadow[key] : init_val(a);
   endfunction

   // Memory array: filled with a known pattern on the first edge, then written on enable+we.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int d = 0; d < N; d++)
            for (int a = 0; a < 65536; a++)
               mem[d][a] <= init_val(16'(a));
         mem_ready <= 1'b1;
      end else begin
         for (int d = 0; d < N; d++)
            if (mem_en[d] && mem_we[d]) mem[d][mem_addr[d]] <= mem_wdata[d];
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < N; d++) begin
         exp_cpu_rd[d] = 8'h00;
         exp_ldr_rd[d] = 8'h00;
      end
      @(negedge clk);
   endtask

   // One isolated transaction, starting with the DUT idle; checks every cycle of it.
   task automatic run_txn(input int d, input bit port, input bit we, input logic [15:0] addr,
                          input logic [7:0] wdata, input bit move_addr);
      int lat;
      logic [7:0] old_cpu, old_ldr;
      lat = lat_of(d);
      old_cpu = exp_cpu_rd[d];
      old_ldr = exp_ldr_rd[d];
      if (!port) begin
         cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wdata;
      end else begin
         ldr_req[d] = 1'b1; ldr_we[d] = we; ldr_addr[d] = addr; ldr_wdata[d] = wdata;
      end
      @(negedge clk);
      for (int c = 1; c <= lat; c++) begin
         if (move_addr && c == 1) begin
            cpu_addr[d] = addr + 16'h0010; ldr_addr[d] = addr + 16'h0010;
            cpu_wdata[d] = ~wdata; ldr_wdata[d] = ~wdata;
            cpu_we[d] = ~we; ldr_we[d] = ~we;
         end
         checks++; if (mem_en[d] !== 1'b1) begin failures++; $display("FAIL access_en d=%0d cyc=%0d got=%b exp=1", d, c, mem_en[d]); end
         checks++; if (mem_we[d] !== we) begin failures++; $display("FAIL access_we d=%0d cyc=%0d got=%b exp=%b", d, c, mem_we[d], we); end
         checks++; if (mem_addr[d] !== addr) begin failures++; $display("FAIL access_addr d=%0d cyc=%0d got=%h exp=%h", d, c, mem_addr[d], addr); end
         if (we) begin
            checks++; if (mem_wdata[d] !== wdata) begin failures++; $display("FAIL access_wdata d=%0d cyc=%0d got=%h exp=%h", d, c, mem_wdata[d], wdata); end
         end
         checks++; if (busy[d] !== 1'b1) begin failures++; $display("FAIL access_busy d=%0d cyc=%0d got=%b exp=1", d, c, busy[d]); end
         checks++; if (owner[d] !== port) begin failures++; $display("FAIL access_owner d=%0d cyc=%0d got=%b exp=%b", d, c, owner[d], port); end
         checks++; if ({cpu_ack[d], ldr_ack[d]} !== 2'b00) begin failures++; $display("FAIL early_ack d=%0d cyc=%0d got=%b%b exp=00", d, c, cpu_ack[d], ldr_ack[d]); end
         checks++; if (stall_cpu[d] !== !port) begin failures++; $display("FAIL access_stall d=%0d cyc=%0d got=%b exp=%b", d, c, stall_cpu[d], !port); end
         checks++; if (cpu_rdata[d] !== old_cpu || ldr_rdata[d] !== old_ldr) begin
            failures++; $display("FAIL rdata_hold d=%0d cyc=%0d got=%h/%h exp=%h/%h", d, c, cpu_rdata[d], ldr_rdata[d], old_cpu, old_ldr);
         end
         @(negedge clk);
      end
      if (we) shadow[d * 65536 + int'(addr)] = wdata;
      else if (!port) exp_cpu_rd[d] = exp_mem(d, addr);
      else exp_ldr_rd[d] = exp_mem(d, addr);
      checks++; if ({cpu_ack[d], ldr_ack[d]} !== {!port, port}) begin
         failures++; $display("FAIL resp_ack d=%0d got=%b%b exp=%b%b", d, cpu_ack[d], ldr_ack[d], !port, port);
      end
      checks++; if ({mem_en[d], mem_we[d], busy[d]} !== 3'b001) begin
         failures++; $display("FAIL resp_strobes d=%0d got=%b%b%b exp=001", d, mem_en[d], mem_we[d], busy[d]);
      end
      checks++; if (stall_cpu[d] !== 1'b0) begin failures++; $display("FAIL resp_stall d=%0d got=%b exp=0", d, stall_cpu[d]); end
      checks++; if (cpu_rdata[d] !== exp_cpu_rd[d] || ldr_rdata[d] !== exp_ldr_rd[d]) begin
         failures++; $display("FAIL resp_rdata d=%0d got=%h/%h exp=%h/%h", d, cpu_rdata[d], ldr_rdata[d], exp_cpu_rd[d], exp_ldr_rd[d]);
      end
      cpu_req[d] = 1'b0;
      ldr_req[d] = 1'b0;
      @(negedge clk);
      checks++; if ({cpu_ack[d], ldr_ack[d], busy[d], mem_en[d]} !== 4'b0000) begin
         failures++; $display("FAIL idle_after d=%0d got=%b%b%b%b exp=0000", d, cpu_ack[d], ldr_ack[d], busy[d], mem_en[d]);
      end
      checks++; if (owner[d] !== port) begin failures++; $display("FAIL owner_hold d=%0d got=%b exp=%b", d, owner[d], port); end
      $display("txn d=%0d port=%s we=%0d addr=%h data=%h", d, port ? "ldr" : "cpu", we, addr,
               we ? wdata : (port ? exp_ldr_rd[d] : exp_cpu_rd[d]));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
         checks++; if ({cpu_ack[d], ldr_ack[d], mem_en[d], mem_we[d], busy[d], owner[d], stall_cpu[d]} !== 7'b0) begin
            failures++; $display("FAIL reset_flags d=%0d got=%b%b%b%b%b%b%b exp=0", d, cpu_ack[d], ldr_ack[d], mem_en[d], mem_we[d], busy[d], owner[d], stall_cpu[d]);
         end
         checks++; if ({cpu_rdata[d], ldr_rdata[d]} !== 16'h0000) begin
            failures++; $display("FAIL reset_rdata d=%0d got=%h/%h exp=00/00", d, cpu_rdata[d], ldr_rdata[d]);
         end
         checks++; if ({mem_addr[d], mem_wdata[d]} !== 24'h0) begin
            failures++; $display("FAIL reset_bus d=%0d got=%h/%h exp=0000/00", d, mem_addr[d], mem_wdata[d]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_cpu_read();
      run_txn(0, 1'b1, 1'b1, 16'h0800, 8'h3C, 1'b0);
      do_reset();
      checks++; if (cpu_rdata[0] !== 8'h00) begin failures++; $display("FAIL cpu_rd_cleared got=%h exp=00", cpu_rdata[0]); end
      run_txn(0, 1'b0, 1'b0, 16'h0800, 8'h00, 1'b0);
      checks++; if (cpu_rdata[0] !== 8'h3C) begin failures++; $display("FAIL cpu_read_0800 got=%h exp=3c", cpu_rdata[0]); end
   endtask

   task automatic test_ldr_write();
      run_txn(1, 1'b1, 1'b1, 16'h2000, 8'hA5, 1'b0);
      run_txn(1, 1'b0, 1'b0, 16'h2000, 8'h00, 1'b0);
      checks++; if (cpu_rdata[1] !== 8'hA5) begin failures++; $display("FAIL readback_2000 got=%h exp=a5", cpu_rdata[1]); end
   endtask

   task automatic test_addr_hold();
      run_txn(1, 1'b0, 1'b0, 16'h0010, 8'h00, 1'b1);
      run_txn(0, 1'b1, 1'b1, 16'h0030, 8'hC3, 1'b1);
   endtask

   task automatic test_reset_mid();
      run_txn(1, 1'b0, 1'b0, 16'h0301, 8'h00, 1'b0);
      run_txn(1, 1'b1, 1'b0, 16'h0302, 8'h00, 1'b0);
      cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 16'h0300;
      @(negedge clk);
      @(negedge clk);
      checks++; if (mem_en[1] !== 1'b1) begin failures++; $display("FAIL pre_abort_en got=%b exp=1", mem_en[1]); end
      rst = 1'b1;
      #1;
      for (int d = 0; d < N; d++) begin
         checks++; if ({mem_en[d], mem_we[d], busy[d], cpu_ack[d], ldr_ack[d]} !== 5'b0) begin
            failures++; $display("FAIL abort_strobes d=%0d got=%b%b%b%b%b exp=0", d, mem_en[d], mem_we[d], busy[d], cpu_ack[d], ldr_ack[d]);
         end
         checks++; if ({cpu_rdata[d], ldr_rdata[d]} !== 16'h0000) begin
            failures++; $display("FAIL abort_rdata d=%0d got=%h/%h exp=00/00", d, cpu_rdata[d], ldr_rdata[d]);
         end
         exp_cpu_rd[d] = 8'h00;
         exp_ldr_rd[d] = 8'h00;
      end
      cpu_req[1] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if ({cpu_ack[1], ldr_ack[1], busy[1]} !== 3'b000) begin
            failures++; $display("FAIL abort_no_ack cyc=%0d got=%b%b%b exp=000", c, cpu_ack[1], ldr_ack[1], busy[1]);
         end
      end
   endtask

   // Both requesters always want the memory; each drops req for one cycle after its ack.
   task automatic test_round_robin(input int d, input bit with_reset);
      int lat, period, k, cpu_drop, ldr_drop, obs_cpu, obs_ldr;
      bit exp_c, exp_l, ldr_window, exp_busy;
      if (with_reset) do_reset();
      lat = lat_of(d);
      period = lat + 2;
      cpu_drop = -10; ldr_drop = -10; obs_cpu = 0; obs_ldr = 0;
      cpu_we[d] = 1'b0; ldr_we[d] = 1'b0;
      cpu_addr[d] = 16'h0100; ldr_addr[d] = 16'h0200;
      cpu_req[d] = 1'b1; ldr_req[d] = 1'b1;
      for (int t = 0; t < 4 * period; t++) begin
         if (t > 0) begin
            exp_c = 1'b0; exp_l = 1'b0;
            k = t / period;
            ldr_window = (k % 2 == 1) && (t % period != 0);
            exp_busy = (t % period != 0);
            if (t >= lat + 1 && (t - lat - 1) % period == 0) begin
               exp_c = ((t - lat - 1) / period) % 2 == 0;
               exp_l = !exp_c;
            end
            obs_cpu += int'(cpu_ack[d]);
            obs_ldr += int'(ldr_ack[d]);
            checks++; if ({cpu_ack[d], ldr_ack[d]} !== {exp_c, exp_l}) begin
               failures++; $display("FAIL rr_ack d=%0d t=%0d got=%b%b exp=%b%b", d, t, cpu_ack[d], ldr_ack[d], exp_c, exp_l);
            end
            checks++; if (busy[d] !== exp_busy) begin failures++; $display("FAIL rr_busy d=%0d t=%0d got=%b exp=%b", d, t, busy[d], exp_busy); end
            checks++; if (stall_cpu[d] !== (cpu_req[d] && !exp_c)) begin
               failures++; $display("FAIL rr_stall d=%0d t=%0d got=%b exp=%b", d, t, stall_cpu[d], cpu_req[d] && !exp_c);
            end
            if (ldr_window) begin
               checks++; if (stall_cpu[d] !== 1'b1) begin failures++; $display("FAIL rr_stall_ldr d=%0d t=%0d got=%b exp=1", d, t, stall_cpu[d]); end
            end
            if (exp_c || exp_l) begin
               if (exp_c) exp_cpu_rd[d] = exp_mem(d, 16'h0100);
               else exp_ldr_rd[d] = exp_mem(d, 16'h0200);
               checks++; if (owner[d] !== exp_l) begin failures++; $display("FAIL rr_owner d=%0d t=%0d got=%b exp=%b", d, t, owner[d], exp_l); end
               checks++; if (cpu_rdata[d] !== exp_cpu_rd[d] || ldr_rdata[d] !== exp_ldr_rd[d]) begin
                  failures++; $display("FAIL rr_rdata d=%0d t=%0d got=%h/%h exp=%h/%h", d, t, cpu_rdata[d], ldr_rdata[d], exp_cpu_rd[d], exp_ldr_rd[d]);
               end
               $display("txn d=%0d rr t=%0d port=%s rdata=%h", d, t, exp_l ? "ldr" : "cpu", exp_l ? ldr_rdata[d] : cpu_rdata[d]);
            end
         end
         if (cpu_ack[d]) begin cpu_req[d] = 1'b0; cpu_drop = t; end
         else if (!cpu_req[d] && t == cpu_drop + 1) cpu_req[d] = 1'b1;
         if (ldr_ack[d]) begin ldr_req[d] = 1'b0; ldr_drop = t; end
         else if (!ldr_req[d] && t == ldr_drop + 1) ldr_req[d] = 1'b1;
         @(negedge clk);
      end
      cpu_req[d] = 1'b0;
      ldr_req[d] = 1'b0;
      checks++; if (obs_cpu != 2 || obs_ldr != 2) begin
         failures++; $display("FAIL rr_count d=%0d got=%0d/%0d exp=2/2", d, obs_cpu, obs_ldr);
      end
      @(negedge clk);
   endtask

   task automatic test_hold();
      run_txn(0, 1'b1, 1'b1, 16'h1234, 8'h77, 1'b0);
      run_txn(0, 1'b1, 1'b0, 16'h1234, 8'h00, 1'b0);
      checks++; if (ldr_rdata[0] !== 8'h77) begin failures++; $display("FAIL ldr_read_77 got=%h exp=77", ldr_rdata[0]); end
      run_txn(0, 1'b0, 1'b1, 16'h0042, 8'h99, 1'b0);
      checks++; if (ldr_rdata[0] !== 8'h77) begin failures++; $display("FAIL ldr_hold_77 got=%h exp=77", ldr_rdata[0]); end
   endtask

   task automatic test_random();
      int d, gap;
      bit port, we, mv;
      logic [15:0] addr;
      logic [7:0] data;
      for (int i = 0; i < 40; i++) begin
         d = int'($urandom_range(0, 1));
         port = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         mv = 1'($urandom_range(0, 1));
         addr = 16'h3000 + 16'($urandom_range(0, 7));
         data = 8'($urandom);
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) @(negedge clk);
         run_txn(d, port, we, addr, data, mv);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < N; d++) begin
         cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = 16'h0; cpu_wdata[d] = 8'h0;
         ldr_req[d] = 1'b0; ldr_we[d] = 1'b0; ldr_addr[d] = 16'h0; ldr_wdata[d] = 8'h0;
         exp_cpu_rd[d] = 8'h00; exp_ldr_rd[d] = 8'h00;
      end
      @(negedge clk);
      test_reset();
      test_cpu_read();
      test_ldr_write();
      test_addr_hold();
      test_reset_mid();
      test_round_robin(1, 1'b0);
      test_round_robin(0, 1'b1);
      test_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single 64K x 8 memory between two requesters.
  - The CPU path: MAR/MDR accesses sequenced by the controller-sequencer.
  - The front-panel/serial program loader.
- Serialises accesses, latches address/data per transaction and returns read data with a one-cycle acknowledge.
- Sits between the requesters and the memory array.
- Drives a stall indication back to the controller-sequencer.

Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 8, memory data width
- MEM_LAT, 1, cycles the memory enable is held per access (legal 1..4)

Ports:
- iClk  in  1  system clock; all state updates on rising edge
- iRst  in  1  asynchronous active-high reset
- iCpuReq  in  1  CPU access request; level, held until oCpuAck
- iCpuWe  in  1  1 = write, 0 = read
- iCpuAddr  in  ADDR_W  CPU address
- iCpuWdata  in  DATA_W  CPU write data
- oCpuAck  out  1  one-cycle completion pulse
- oCpuRdata  out  DATA_W  CPU read data
- iLdrReq  in  1  loader access request; level, held until oLdrAck
- iLdrWe  in  1  loader write enable
- iLdrAddr  in  ADDR_W  loader address
- iLdrWdata  in  DATA_W  loader write data
- oLdrAck  out  1  one-cycle completion pulse
- oLdrRdata  out  DATA_W  loader read data
- oMemAddr  out  ADDR_W  address to memory
- oMemWdata  out  DATA_W  write data to memory
- oMemEn  out  1  memory access enable
- oMemWe  out  1  memory write strobe
- iMemRdata  in  DATA_W  memory read data
- oBusy  out  1  transaction in progress
- oOwner  out  1  current/last grant: 0 = CPU, 1 = loader
- oStallCpu  out  1  CPU request pending but not yet acknowledged

Behaviour:
- Reset (async, iRst = 1): state IDLE; every output 0; last-grant pointer set so that the CPU wins the first tie.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requests: grant the one not granted last (round robin).
  - On grant: latch addr/wdata/we and the owner; load the access counter with MEM_LAT-1; go to ACCESS.
- ACCESS:
  - oMemEn = 1 and oMemAddr/oMemWdata driven from latched values.
  - oMemWe = latched we, for every ACCESS cycle.
  - Counter decrements each cycle. At counter = 0, a read captures iMemRdata into the owner's rdata register; go to RESP.
- RESP:
  - Owner's ack = 1 for exactly one cycle.
  - oMemEn = 0, oMemWe = 0.
  - Go to IDLE.
- Latency: request seen in IDLE at cycle 0; ACCESS occupies cycles 1..MEM_LAT; ack at cycle MEM_LAT+1.
  - Back-to-back transactions are spaced MEM_LAT+2 cycles apart.
- Requesters must deassert req in the cycle following ack. A req still high in IDLE is a new request.
- Requester-side changes to addr/wdata/we during ACCESS or RESP are ignored (latched copy used).
- Req dropped mid-transaction: the access still completes and the ack still pulses.
- Rdata registers:
  - Updated only on a read completion for that port.
  - Held otherwise, including across writes and the other port's transactions.
- oBusy = 1 in ACCESS and RESP.
- oOwner updates at grant and holds through IDLE.
- oStallCpu = iCpuReq & ~oCpuAck (combinational). It is 1 while the loader owns memory.
- Reset asserted mid-access: the access aborts immediately. No ack; rdata cleared; oMemEn/oMemWe drop asynchronously.
- MEM_LAT outside 1..4 is a configuration error; flag it with an elaboration-time assertion.
- Never more than one ack high per cycle; oMemEn is never high in IDLE.

Decomposition:
- Shared package mpu_mem_pkg holds:
  - state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2)
  - owner constants OWN_CPU = 1'b0, OWN_LDR = 1'b1
  - ADDR_W/DATA_W defaults
- One natural sub-module: mem_access_timer, a loadable down-counter with a zero flag.
- Arbitration and the FSM stay in the top block.

Test Plan:
- Reset then CPU read, MEM_LAT = 1: iCpuReq = 1, iCpuAddr = 16'h0800, memory holds 8'h3C.
  - Required: oMemEn in cycle 1 with oMemAddr = 16'h0800; oCpuAck pulse in cycle 2; oCpuRdata = 8'h3C; oLdrAck stays 0.
- Loader write, MEM_LAT = 3: addr 16'h2000, data 8'hA5.
  - Required: oMemEn = oMemWe = 1 for cycles 1–3 with oMemWdata = 8'hA5; oLdrAck in cycle 4; a following CPU read of 16'h2000 returns 8'hA5.
- Simultaneous requests from reset, held continuously with req dropped one cycle after each ack and then reasserted.
  - Required: grant order CPU, loader, CPU, loader; acks alternate and are spaced MEM_LAT+2 cycles apart; oStallCpu = 1 during loader transactions.
- Address change mid-access: the CPU changes iCpuAddr from 16'h0010 to 16'h0020 during ACCESS.
  - Required: oMemAddr stays 16'h0010 through the whole access.
- iRst pulsed in the 2nd ACCESS cycle, MEM_LAT = 3.
  - Required: oMemEn, oMemWe and oBusy drop to 0 immediately; no ack; both rdata = 8'h00; the next CPU request wins the tie.
- Loader read of 8'h77 followed by a CPU write.
  - Required: oLdrRdata holds 8'h77 unchanged throughout the CPU transaction.
